// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA timing generator.
package vga_pkg;

  // Line/frame phase, shared by the horizontal and vertical FSMs.
  typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter, phase FSM and last-visible position.
// Exposes next-cycle values so the top can register outputs with zero latency.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACT_W  = DEF_H_ACTIVE,
  parameter int FP_W   = DEF_H_FP,
  parameter int SYNC_W = DEF_H_SYNC,
  parameter int BP_W   = DEF_H_BP,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic [CNT_W-1:0] pos,
  output logic             act_nxt,
  output logic             sync_nxt
);

  localparam int TOTAL = ACT_W + FP_W + SYNC_W + BP_W;

  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACT_W - 1);
  localparam logic [CNT_W-1:0] FP_END   = CNT_W'(ACT_W + FP_W - 1);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACT_W + FP_W + SYNC_W - 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_LIM  = CNT_W'(ACT_W);

  phase_t           phase, phase_nxt;
  logic [CNT_W-1:0] pos_nxt;
  logic             wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= ACT;
      pos   <= '0;
    end else begin
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
      pos   <= pos_nxt;
    end
  end

  // Phase changes on the enabled cycle where the count sits on a boundary.
  always_comb begin
    wrap    = en && (cnt == LAST);
    cnt_nxt = cnt;
    if (en) cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
    phase_nxt = phase;
    if (en) begin
      case (phase)
        ACT:  if (cnt == ACT_END)  phase_nxt = FP;
        FP:   if (cnt == FP_END)   phase_nxt = SYNC;
        SYNC: if (cnt == SYNC_END) phase_nxt = BP;
        BP:   if (wrap)            phase_nxt = ACT;
      endcase
    end
  end

  always_comb begin
    act_nxt  = (phase_nxt == ACT);
    sync_nxt = (phase_nxt == SYNC);
    pos_nxt  = (cnt_nxt < ACT_LIM) ? cnt_nxt : pos;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, sync pulses and visible-area flags.
// Define VGA_TIMING_PIPE_EN to delay every output one pix_en tick for memory alignment.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic [CNT_W-1:0] posx,
  output logic [CNT_W-1:0] posy,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam int OW = 4*CNT_W + 5;

  logic [CNT_W-1:0] h_cnt, h_cnt_nxt, h_pos;
  logic [CNT_W-1:0] v_cnt, v_cnt_nxt, v_pos;
  logic             h_act_nxt, h_sync_nxt, v_act_nxt, v_sync_nxt;
  logic             h_wrap, v_en;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_en   = pix_en & h_wrap;

  vga_axis_counter #(
    .ACT_W(H_ACTIVE), .FP_W(H_FP), .SYNC_W(H_SYNC), .BP_W(H_BP), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .rst(rst), .en(pix_en),
    .cnt(h_cnt), .cnt_nxt(h_cnt_nxt), .pos(h_pos),
    .act_nxt(h_act_nxt), .sync_nxt(h_sync_nxt)
  );

  vga_axis_counter #(
    .ACT_W(V_ACTIVE), .FP_W(V_FP), .SYNC_W(V_SYNC), .BP_W(V_BP), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .rst(rst), .en(v_en),
    .cnt(v_cnt), .cnt_nxt(v_cnt_nxt), .pos(v_pos),
    .act_nxt(v_act_nxt), .sync_nxt(v_sync_nxt)
  );

  logic von0, hs0, vs0, ls0, fs0;

  // Flags are built from next-cycle counter/phase so they line up with hcount/vcount.
  always_ff @(posedge clk) begin
    if (rst) begin
      von0 <= 1'b1;
      hs0  <= ~HS_POL;
      vs0  <= ~VS_POL;
      ls0  <= 1'b1;
      fs0  <= 1'b1;
    end else if (pix_en) begin
      von0 <= h_act_nxt & v_act_nxt;
      hs0  <= h_sync_nxt ? HS_POL : ~HS_POL;
      vs0  <= v_sync_nxt ? VS_POL : ~VS_POL;
      ls0  <= (h_cnt_nxt == '0);
      fs0  <= (h_cnt_nxt == '0) && (v_cnt_nxt == '0);
    end
  end

  logic [OW-1:0] out0;
  assign out0 = {h_cnt, v_cnt, h_pos, v_pos, von0, hs0, vs0, ls0, fs0};

`ifdef VGA_TIMING_PIPE_EN
  localparam logic [OW-1:0] OUT_RST = {{(4*CNT_W){1'b0}}, 1'b1, ~HS_POL, ~VS_POL, 1'b1, 1'b1};
  logic [OW-1:0] out1;

  always_ff @(posedge clk) begin
    if (rst)         out1 <= OUT_RST;
    else if (pix_en) out1 <= out0;
  end

  assign {hcount, vcount, posx, posy, video_on, hsync, vsync, line_start, frame_start} = out1;
`else
  assign {hcount, vcount, posx, posy, video_on, hsync, vsync, line_start, frame_start} = out0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing and reduced-timing instances share stimulus
// and are compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 1;
  localparam int SW  = 5;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]    d_h, d_v, d_px, d_py;
  logic          d_von, d_hs, d_vs, d_ls, d_fs;
  logic [SW-1:0] s_h, s_v, s_px, s_py;
  logic          s_von, s_hs, s_vs, s_ls, s_fs;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(d_h), .vcount(d_v), .posx(d_px), .posy(d_py),
    .video_on(d_von), .hsync(d_hs), .vsync(d_vs),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .CNT_W(SW), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(s_h), .vcount(s_v), .posx(s_px), .posy(s_py),
    .video_on(s_von), .hsync(s_hs), .vsync(s_vs),
    .line_start(s_ls), .frame_start(s_fs)
  );

  typedef struct {
    int h, v, px, py;
    bit von, hs, vs, ls, fs;
  } exp_t;

  typedef struct {
    bit r; bit e; int h; bit von; bit hs; bit ls;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int mt = 0;

  // Position in the raster is just the tick count since reset folded by the totals.
  function automatic exp_t model(input int t, input int ha, hf, hsw, hb,
                                 input int va, vf, vsw, vb, input bit hp, vp);
    exp_t e;
    int ht, vt;
    ht    = ha + hf + hsw + hb;
    vt    = va + vf + vsw + vb;
    e.h   = t % ht;
    e.v   = (t / ht) % vt;
    e.px  = (e.h < ha) ? e.h : ha - 1;
    e.py  = (e.v < va) ? e.v : va - 1;
    e.von = (e.h < ha) && (e.v < va);
    e.hs  = (e.h >= ha + hf && e.h < ha + hf + hsw) ? hp : !hp;
    e.vs  = (e.v >= va + vf && e.v < va + vf + vsw) ? vp : !vp;
    e.ls  = (e.h == 0);
    e.fs  = (e.h == 0) && (e.v == 0);
    return e;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (tick %0d)", nm, act, exp, mt);
    end
  endtask

  task automatic check_all();
    int t;
    exp_t ed, es;
    t = mt;
`ifdef VGA_TIMING_PIPE_EN
    if (t > 0) t--;
`endif
    ed = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    es = model(t, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 1'b1);
    cmp("d_hcount", d_h, ed.h);     cmp("d_vcount", d_v, ed.v);
    cmp("d_posx", d_px, ed.px);     cmp("d_posy", d_py, ed.py);
    cmp("d_video_on", d_von, ed.von); cmp("d_hsync", d_hs, ed.hs);
    cmp("d_vsync", d_vs, ed.vs);    cmp("d_line_start", d_ls, ed.ls);
    cmp("d_frame_start", d_fs, ed.fs);
    cmp("s_hcount", s_h, es.h);     cmp("s_vcount", s_v, es.v);
    cmp("s_posx", s_px, es.px);     cmp("s_posy", s_py, es.py);
    cmp("s_video_on", s_von, es.von); cmp("s_hsync", s_hs, es.hs);
    cmp("s_vsync", s_vs, es.vs);    cmp("s_line_start", s_ls, es.ls);
    cmp("s_frame_start", s_fs, es.fs);
  endtask

  task automatic step(input bit r, input bit e);
    rst    = r;
    pix_en = e;
    @(posedge clk);
    if (r)      mt = 0;
    else if (e) mt++;
    #1;
    check_all();
  endtask

  initial begin
    vec_t tbl[$];
    vec_t pe, prev;
    int   hits;
    bit   found;

    step(1'b1, 1'b0);

    // Table: reset with pix_en high, run to hcount 10, then the 1,0,0,1 enable pattern.
    tbl.push_back('{1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b1});
    for (int i = 1; i <= 10; i++) tbl.push_back('{1'b0, 1'b1, i, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 11, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 11, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 11, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 12, 1'b1, 1'b1, 1'b0});
    prev = tbl[0];
    pe   = tbl[0];
    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].e);
`ifdef VGA_TIMING_PIPE_EN
      if (tbl[k].r)      pe = tbl[k];
      else if (tbl[k].e) pe = prev;
`else
      pe = tbl[k];
`endif
      prev = tbl[k];
      cmp("tbl_hcount", d_h, pe.h);
      cmp("tbl_video_on", d_von, pe.von);
      cmp("tbl_hsync", d_hs, pe.hs);
      cmp("tbl_line_start", d_ls, pe.ls);
    end

    // Default-timing line edges: visible-area fall and hsync window.
    step(1'b1, 1'b0);
    hits = 0;
    for (int i = 0; i < 1700; i++) begin
      step(1'b0, 1'b1);
      case (d_h)
        10'd639: begin cmp("von_at_639", d_von, 1);   hits++; end
        10'd640: begin cmp("von_at_640", d_von, 0);   hits++; end
        10'd655: begin cmp("hs_at_655", d_hs, 1);     hits++; end
        10'd656: begin cmp("hs_at_656", d_hs, 0);     hits++; end
        10'd751: begin cmp("hs_at_751", d_hs, 0);     hits++; end
        10'd752: begin cmp("hs_at_752", d_hs, 1);     hits++; end
        10'd700: begin cmp("posx_hold", d_px, 639);   hits++; end
        default: ;
      endcase
    end
    cmp("edge_spots_hit", hits, 14);

    // Reduced-timing frame wrap: last pixel of the frame into (0,0).
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (s_v == SW'(SVT - 1) && s_h == SW'(SHT - 1)) found = 1'b1;
      else step(1'b0, 1'b1);
    end
    cmp("frame_end_reached", found, 1);
    step(1'b0, 1'b1);
    cmp("wrap_vcount", s_v, 0);
    cmp("wrap_hcount", s_h, 0);
    cmp("wrap_frame_start", s_fs, 1);
    step(1'b0, 1'b1);
    cmp("frame_start_one_pixel", s_fs, 0);

    // Mid-frame reset restarts at (0,0) with both syncs inactive.
    step(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (s_h == SW'(10) && s_v == SW'(4)) found = 1'b1;
      else step(1'b0, 1'b1);
    end
    cmp("midframe_reached", found, 1);
    step(1'b1, 1'b1);
    cmp("rst_hcount", s_h, 0);
    cmp("rst_vcount", s_v, 0);
    cmp("rst_video_on", s_von, 1);
    cmp("rst_hsync", s_hs, 0);
    cmp("rst_vsync", s_vs, 0);
    cmp("rst_frame_start", s_fs, 1);
    step(1'b0, 1'b1);
    cmp("post_rst_hsync", s_hs, 0);

    // Random enables with occasional resets.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
